// File: rtl/gemm_out_collector.sv
// Collects the gemm kernel's output streams, sums every result word and shifts the checksum out as nibbles.
// Optional COLLECT_OVF_EN: adds sticky ovf_err and forces 32'hDEADBEEF out when it is set at SHIFT entry.

// Generic synchronous FIFO with occupancy count.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module gemm_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
endmodule

// Buffers each lane, round-robin pops one word per cycle into the checksum, then serialises it.
// Latency: accept to earliest pop 1 cycle; last pop to first data_valid 1 cycle.
// Backpressure: D_out_full_n per lane from registered state only; refused writes are dropped.
module gemm_out_collector #(
  parameter int LANES          = 8,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LANE = 128,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [LANES*DATA_W-1:0]   D_out_din,
  input  logic [LANES-1:0]          D_out_write,
  output logic [LANES-1:0]          D_out_full_n,
  output logic [3:0]                data_out,
  output logic                      data_valid,
  output logic                      probe_out
`ifdef COLLECT_OVF_EN
  ,
  output logic                      ovf_err
`endif
);
  localparam int CW   = $clog2(FIFO_DEPTH+1);
  localparam int QW   = $clog2(WORDS_PER_LANE+1);
  localparam int TW   = $clog2(LANES*WORDS_PER_LANE+1);
  localparam int PW   = $clog2(LANES);
  localparam int NIBS = DATA_W/4;
  localparam int NW   = $clog2(NIBS);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [QW-1:0] QUOTA_C  = QW'(WORDS_PER_LANE);
  localparam logic [TW-1:0] TOTAL_C  = TW'(LANES*WORDS_PER_LANE);
  localparam logic [NW-1:0] LAST_NIB = NW'(NIBS-1);

  typedef enum logic [1:0] {COLLECT, SHIFT, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                rst_q;
  logic [CW-1:0]       lane_cnt  [LANES];
  logic [QW-1:0]       quota_cnt [LANES];
  logic [DATA_W-1:0]   lane_dat  [LANES];
  logic [LANES-1:0]    push;
  logic [LANES-1:0]    pop;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       grant_idx;
  logic                grant_vld;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   acc_nxt;
  logic [DATA_W-1:0]   ser;
  logic [DATA_W-1:0]   ser_load;
  logic [TW-1:0]       total;
  logic [NW-1:0]       nib_cnt;
  logic                last_pop;

  // rst_q holds full_n low for every cycle reset was sampled, without a path from ap_rst itself.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign D_out_full_n[i] = !rst_q && (state == COLLECT) &&
                             (lane_cnt[i] < DEPTH_C) && (quota_cnt[i] < QUOTA_C);
    assign push[i] = D_out_write[i] && D_out_full_n[i];
    assign pop[i]  = grant_vld && (grant_idx == PW'(i));

    gemm_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (ap_clk),
      .rst      (ap_rst),
      .push     (push[i]),
      .push_dat (D_out_din[i*DATA_W +: DATA_W]),
      .pop      (pop[i]),
      .pop_dat  (lane_dat[i]),
      .count    (lane_cnt[i])
    );

    always_ff @(posedge ap_clk) begin
      if (ap_rst)       quota_cnt[i] <= '0;
      else if (push[i]) quota_cnt[i] <= quota_cnt[i] + QW'(1);
    end
  end

  // rr_ptr holds the lane to try first, i.e. one past the last grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!grant_vld && (state == COLLECT) &&
          (lane_cnt[PW'((int'(rr_ptr) + k) % LANES)] != '0)) begin
        grant_vld = 1'b1;
        grant_idx = PW'((int'(rr_ptr) + k) % LANES);
      end
    end
  end

  assign acc_nxt  = acc + (grant_vld ? lane_dat[grant_idx] : '0);
  assign last_pop = grant_vld && (total == TOTAL_C - TW'(1));

`ifdef COLLECT_OVF_EN
  logic [LANES-1:0] quota_hit;
  logic             ovf_now;

  always_comb begin
    quota_hit = '0;
    for (int i = 0; i < LANES; i++) quota_hit[i] = (quota_cnt[i] == QUOTA_C);
  end

  // Occupancy-only refusals are normal flow control and do not count as overflow.
  assign ovf_now  = |(D_out_write & ~D_out_full_n & (quota_hit | {LANES{state != COLLECT}}));
  assign ser_load = (ovf_err || ovf_now) ? DATA_W'(32'hDEADBEEF) : acc_nxt;

  always_ff @(posedge ap_clk) begin
    if (ap_rst)       ovf_err <= 1'b0;
    else if (ovf_now) ovf_err <= 1'b1;
  end
`else
  assign ser_load = acc_nxt;
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    data_valid = 1'b0;
    data_out   = 4'h0;
    probe_out  = 1'b0;
    case (state)
      COLLECT: if (last_pop) state_nxt = SHIFT;
      SHIFT: begin
        data_valid = 1'b1;
        data_out   = ser[DATA_W-1 -: 4];
        if (nib_cnt == LAST_NIB) state_nxt = DONE;
      end
      DONE:    probe_out = 1'b1;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    rst_q <= ap_rst;
    if (ap_rst) begin
      acc     <= '0;
      total   <= '0;
      rr_ptr  <= '0;
      ser     <= '0;
      nib_cnt <= '0;
    end else begin
      if (grant_vld) begin
        acc    <= acc_nxt;
        total  <= total + TW'(1);
        rr_ptr <= (grant_idx == PW'(LANES-1)) ? '0 : grant_idx + PW'(1);
      end
      if (state == COLLECT && last_pop) begin
        ser     <= ser_load;
        nib_cnt <= '0;
      end else if (state == SHIFT) begin
        ser     <= ser << 4;
        nib_cnt <= nib_cnt + NW'(1);
      end
    end
  end
endmodule
